// File: rtl/orb_word_checker_pkg.sv
// Shared definitions for the orbit word checker: frame-sync state encoding,
// default word geometry and a saturating error-counter helper.
package orb_word_checker_pkg;

   localparam int          WORD_BITS_C   = 12;
   localparam int          FRAME_WORDS_C = 1024;
   localparam logic [11:0] SYNC_WORD_C   = 12'hE2B;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'b00,
      ST_VERIFY = 2'b01,
      ST_LOCKED = 2'b10
   } orb_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/orb_deser.sv
// Serial-to-word deserialiser: shifts bits in MSB first, counts bits and
// flags word boundaries that arrive at the wrong bit count. The flags are
// combinational so the owner can register them with one cycle of latency.
module orb_deser
   import orb_word_checker_pkg::*;
#(
   parameter int WORD_BITS = WORD_BITS_C
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_bit_en,
   input  logic                 i_serial,
   input  logic                 i_word_valid,
   output logic [WORD_BITS-1:0] o_word,
   output logic                 o_word_done,
   output logic                 o_align_err
);

   logic [WORD_BITS-1:0] r_shift;
   logic [3:0]           r_bitcnt;
   logic [WORD_BITS-1:0] w_shift_next;
   logic [4:0]           w_cnt_incl;
   logic                 w_boundary;
   logic                 w_overrun;

   // Next shift value, count including the current bit, boundary classification.
   always_comb begin
      w_shift_next = {r_shift[WORD_BITS-2:0], i_serial};
      w_cnt_incl   = {1'b0, r_bitcnt} + 5'd1;
      w_boundary   = i_bit_en & i_word_valid;
      // A 16th bit with no boundary cannot belong to any legal word.
      w_overrun    = i_bit_en & ~i_word_valid & (r_bitcnt == 4'd15);
      o_word       = w_shift_next;
      o_word_done  = w_boundary & (w_cnt_incl == 5'(WORD_BITS));
      o_align_err  = (w_boundary & (w_cnt_incl != 5'(WORD_BITS))) | w_overrun;
   end

   // Shift register and bit counter; a boundary or overrun restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift  <= '0;
         r_bitcnt <= 4'd0;
      end else if (i_bit_en) begin
         r_shift <= w_shift_next;
         if (w_boundary | w_overrun) begin
            r_bitcnt <= 4'd0;
         end else begin
            r_bitcnt <= r_bitcnt + 4'd1;
         end
      end else begin
         r_shift  <= r_shift;
         r_bitcnt <= r_bitcnt;
      end
   end

endmodule

// File: rtl/orb_word_checker.sv
// Orbit word checker: deserialises the orbit stream, hunts for the frame
// sync word, verifies it over consecutive frames and tracks lock, frame
// index and a saturating error count. All outputs are registered.
module orb_word_checker
   import orb_word_checker_pkg::*;
#(
   parameter int                   WORD_BITS     = WORD_BITS_C,
   parameter int                   FRAME_WORDS   = FRAME_WORDS_C,
   parameter logic [WORD_BITS-1:0] SYNC_WORD     = SYNC_WORD_C,
   parameter int                   LOCK_HITS     = 2,
   parameter int                   UNLOCK_MISSES = 3,
   localparam int                  IDX_W         = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 iBitEn,
   input  logic                 iSerial,
   input  logic                 iWordValid,
   output logic [WORD_BITS-1:0] oWord,
   output logic                 oWordStb,
   output logic [IDX_W-1:0]     oWordIdx,
   output logic                 oFrameStart,
   output logic                 oLocked,
   output logic                 oAlignErr,
   output logic [15:0]          oErrCnt
);

   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(FRAME_WORDS - 1);
   localparam logic [7:0]       LOCK_HITS_C   = 8'(LOCK_HITS);
   localparam logic [7:0]       UNLOCK_MISS_C = 8'(UNLOCK_MISSES);

   logic [WORD_BITS-1:0] w_word;
   logic                 w_word_done;
   logic                 w_align_err;

   orb_state_e           r_state;
   orb_state_e           w_state_next;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_idx_next;
   logic [IDX_W-1:0]     w_idx_wrap;
   logic [7:0]           r_hits;
   logic [7:0]           w_hits_next;
   logic [7:0]           r_misses;
   logic [7:0]           w_miss_next;
   logic                 w_err_inc;
   logic                 w_frame_start;
   logic                 w_sync_match;

   logic [WORD_BITS-1:0] r_word;
   logic                 r_word_stb;
   logic [IDX_W-1:0]     r_word_idx;
   logic                 r_frame_start;
   logic                 r_locked;
   logic                 r_align_err;
   logic [15:0]          r_err_cnt;

   orb_deser #(
      .WORD_BITS (WORD_BITS)
   ) u_deser (
      .clk          (clk),
      .reset        (reset),
      .i_bit_en     (iBitEn),
      .i_serial     (iSerial),
      .i_word_valid (iWordValid),
      .o_word       (w_word),
      .o_word_done  (w_word_done),
      .o_align_err  (w_align_err)
   );

   // Frame-sync FSM next state plus index/hit/miss counter updates.
   always_comb begin
      w_state_next  = r_state;
      w_idx_next    = r_idx;
      w_hits_next   = r_hits;
      w_miss_next   = r_misses;
      w_err_inc     = 1'b0;
      w_frame_start = 1'b0;
      w_sync_match  = (w_word == SYNC_WORD);
      w_idx_wrap    = (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : (r_idx + IDX_W'(1));

      if (w_align_err) begin
         // Lost word alignment: nothing about the frame position can be trusted.
         w_state_next = ST_HUNT;
         w_idx_next   = {IDX_W{1'b0}};
         w_hits_next  = 8'd0;
         w_miss_next  = 8'd0;
         w_err_inc    = 1'b1;
      end else if (w_word_done) begin
         case (r_state)
            ST_HUNT: begin
               if (w_sync_match) begin
                  w_state_next = ST_VERIFY;
                  w_idx_next   = IDX_W'(1);
                  w_hits_next  = 8'd1;
               end else begin
                  w_state_next = ST_HUNT;
               end
            end
            ST_VERIFY: begin
               w_idx_next = w_idx_wrap;
               if (r_idx != {IDX_W{1'b0}}) begin
                  w_state_next = ST_VERIFY;
               end else if (w_sync_match) begin
                  w_hits_next = r_hits + 8'd1;
                  if ((r_hits + 8'd1) >= LOCK_HITS_C) begin
                     w_state_next = ST_LOCKED;
                     w_miss_next  = 8'd0;
                  end else begin
                     w_state_next = ST_VERIFY;
                  end
               end else begin
                  w_state_next = ST_HUNT;
                  w_idx_next   = {IDX_W{1'b0}};
                  w_hits_next  = 8'd0;
               end
            end
            ST_LOCKED: begin
               w_idx_next = w_idx_wrap;
               if (r_idx != {IDX_W{1'b0}}) begin
                  w_state_next = ST_LOCKED;
               end else if (w_sync_match) begin
                  w_miss_next   = 8'd0;
                  w_frame_start = 1'b1;
               end else begin
                  w_miss_next = r_misses + 8'd1;
                  w_err_inc   = 1'b1;
                  if ((r_misses + 8'd1) >= UNLOCK_MISS_C) begin
                     w_state_next = ST_HUNT;
                     w_idx_next   = {IDX_W{1'b0}};
                     w_hits_next  = 8'd0;
                     w_miss_next  = 8'd0;
                  end else begin
                     w_state_next = ST_LOCKED;
                  end
               end
            end
            default: begin
               w_state_next = ST_HUNT;
               w_idx_next   = {IDX_W{1'b0}};
               w_hits_next  = 8'd0;
               w_miss_next  = 8'd0;
            end
         endcase
      end else begin
         w_state_next = r_state;
      end
   end

   // FSM state and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_HUNT;
         r_idx    <= {IDX_W{1'b0}};
         r_hits   <= 8'd0;
         r_misses <= 8'd0;
      end else begin
         r_state  <= w_state_next;
         r_idx    <= w_idx_next;
         r_hits   <= w_hits_next;
         r_misses <= w_miss_next;
      end
   end

   // Registered outputs, one clock after the boundary bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_word        <= '0;
         r_word_stb    <= 1'b0;
         r_word_idx    <= {IDX_W{1'b0}};
         r_frame_start <= 1'b0;
         r_locked      <= 1'b0;
         r_align_err   <= 1'b0;
         r_err_cnt     <= 16'd0;
      end else begin
         r_word_stb    <= w_word_done;
         r_frame_start <= w_frame_start;
         r_locked      <= (w_state_next == ST_LOCKED);
         r_align_err   <= w_align_err;
         r_err_cnt     <= w_err_inc ? sat_inc16(r_err_cnt) : r_err_cnt;
         if (w_word_done) begin
            r_word     <= w_word;
            r_word_idx <= r_idx;
         end else begin
            r_word     <= r_word;
            r_word_idx <= r_word_idx;
         end
      end
   end

   assign oWord       = r_word;
   assign oWordStb    = r_word_stb;
   assign oWordIdx    = r_word_idx;
   assign oFrameStart = r_frame_start;
   assign oLocked     = r_locked;
   assign oAlignErr   = r_align_err;
   assign oErrCnt     = r_err_cnt;

endmodule

// File: tb/tb_orb_word_checker.sv
// Directed bench for orb_word_checker, run with a 16-word frame so frame
// sequences stay short. Single-word behaviour is table driven; sync, lock,
// unlock, reset and saturation are hand-written sequences.
module tb_orb_word_checker;

   localparam int FW = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        iBitEn;
   logic        iSerial;
   logic        iWordValid;
   logic [11:0] oWord;
   logic        oWordStb;
   logic [3:0]  oWordIdx;
   logic        oFrameStart;
   logic        oLocked;
   logic        oAlignErr;
   logic [15:0] oErrCnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] data;
      int          nbits;
      logic        last_valid;
      logic        exp_stb;
      logic        exp_align;
      logic [11:0] exp_word;
      logic [3:0]  exp_idx;
   } vec_t;

   vec_t vecs[9];

   orb_word_checker #(
      .WORD_BITS     (12),
      .FRAME_WORDS   (FW),
      .SYNC_WORD     (12'hE2B),
      .LOCK_HITS     (2),
      .UNLOCK_MISSES (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .iBitEn      (iBitEn),
      .iSerial     (iSerial),
      .iWordValid  (iWordValid),
      .oWord       (oWord),
      .oWordStb    (oWordStb),
      .oWordIdx    (oWordIdx),
      .oFrameStart (oFrameStart),
      .oLocked     (oLocked),
      .oAlignErr   (oAlignErr),
      .oErrCnt     (oErrCnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One bit slot: drive, let one rising edge consume it, return at edge+1.
   task automatic bit_cycle(input logic b, input logic v, input logic en);
      iSerial    = b;
      iWordValid = v;
      iBitEn     = en;
      @(posedge clk);
      #1;
      iBitEn     = 1'b0;
      iWordValid = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] d, input int n, input logic lv);
      for (int i = n - 1; i >= 0; i--) begin
         bit_cycle(d[i], (i == 0) && lv, 1'b1);
      end
   endtask

   task automatic frame_rest();
      for (int k = 1; k < FW; k++) begin
         send_word(16'h0000, 12, 1'b1);
      end
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      iBitEn     = 1'b0;
      iWordValid = 1'b0;
      iSerial    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int exp_err;

      reset      = 1'b0;
      iBitEn     = 1'b0;
      iWordValid = 1'b0;
      iSerial    = 1'b0;
      #1;
      chk("rst_word",  32'(oWord),       32'h0);
      chk("rst_stb",   32'(oWordStb),    32'h0);
      chk("rst_idx",   32'(oWordIdx),    32'h0);
      chk("rst_fs",    32'(oFrameStart), 32'h0);
      chk("rst_lock",  32'(oLocked),     32'h0);
      chk("rst_align", 32'(oAlignErr),   32'h0);
      chk("rst_err",   32'(oErrCnt),     32'h0);

      // ---------------- single-word table ----------------
      vecs[0] = '{16'h0ABC, 12, 1'b1, 1'b1, 1'b0, 12'hABC, 4'd0};
      vecs[1] = '{16'h0000, 12, 1'b1, 1'b1, 1'b0, 12'h000, 4'd0};
      vecs[2] = '{16'h0FFF, 12, 1'b1, 1'b1, 1'b0, 12'hFFF, 4'd0};
      vecs[3] = '{16'h07FF, 11, 1'b1, 1'b0, 1'b1, 12'hFFF, 4'd0};
      vecs[4] = '{16'h1555, 13, 1'b1, 1'b0, 1'b1, 12'hFFF, 4'd0};
      vecs[5] = '{16'h0001,  1, 1'b1, 1'b0, 1'b1, 12'hFFF, 4'd0};
      vecs[6] = '{16'h0123, 16, 1'b0, 1'b0, 1'b1, 12'hFFF, 4'd0};
      vecs[7] = '{16'h0E2B, 12, 1'b1, 1'b1, 1'b0, 12'hE2B, 4'd0};
      vecs[8] = '{16'h0A5A, 12, 1'b1, 1'b1, 1'b0, 12'hA5A, 4'd1};

      do_reset();
      exp_err = 0;
      for (int v = 0; v < 9; v++) begin
         send_word(vecs[v].data, vecs[v].nbits, vecs[v].last_valid);
         if (vecs[v].exp_align) exp_err++;
         chk($sformatf("tbl%0d_stb", v),   32'(oWordStb),  32'(vecs[v].exp_stb));
         chk($sformatf("tbl%0d_align", v), 32'(oAlignErr), 32'(vecs[v].exp_align));
         chk($sformatf("tbl%0d_word", v),  32'(oWord),     32'(vecs[v].exp_word));
         chk($sformatf("tbl%0d_err", v),   32'(oErrCnt),   32'(exp_err));
         chk($sformatf("tbl%0d_lock", v),  32'(oLocked),   32'h0);
         if (vecs[v].exp_stb) begin
            chk($sformatf("tbl%0d_idx", v), 32'(oWordIdx), 32'(vecs[v].exp_idx));
         end
      end
      bit_cycle(1'b0, 1'b0, 1'b0);
      chk("tbl_stb_pulse", 32'(oWordStb), 32'h0);

      // ---------------- acquire lock over three frames ----------------
      do_reset();
      send_word(16'h0E2B, 12, 1'b1);
      chk("f1_stb",  32'(oWordStb), 32'h1);
      chk("f1_lock", 32'(oLocked),  32'h0);
      chk("f1_idx",  32'(oWordIdx), 32'h0);
      frame_rest();
      send_word(16'h0E2B, 12, 1'b1);
      chk("f2_lock", 32'(oLocked),     32'h1);
      chk("f2_fs",   32'(oFrameStart), 32'h0);
      frame_rest();
      send_word(16'h0E2B, 12, 1'b1);
      chk("f3_fs",   32'(oFrameStart), 32'h1);
      chk("f3_lock", 32'(oLocked),     32'h1);
      for (int k = 1; k < FW; k++) begin
         send_word((k == 7) ? 16'h0E2B : 16'h0000, 12, 1'b1);
         if (k == 1) chk("f3_fs_pulse", 32'(oFrameStart), 32'h0);
         if (k == 7) begin
            chk("f3_sync_mid_idx",  32'(oWordIdx),    32'h7);
            chk("f3_sync_mid_fs",   32'(oFrameStart), 32'h0);
            chk("f3_sync_mid_lock", 32'(oLocked),     32'h1);
         end
      end
      chk("f3_err", 32'(oErrCnt), 32'h0);

      // ---------------- three missed sync words ----------------
      for (int f = 0; f < 3; f++) begin
         send_word(16'h0000, 12, 1'b1);
         chk($sformatf("miss%0d_err", f),  32'(oErrCnt), 32'(f + 1));
         chk($sformatf("miss%0d_lock", f), 32'(oLocked), (f < 2) ? 32'h1 : 32'h0);
         chk($sformatf("miss%0d_fs", f),   32'(oFrameStart), 32'h0);
         frame_rest();
      end

      // ---------------- short word while locked ----------------
      do_reset();
      send_word(16'h0E2B, 12, 1'b1);
      frame_rest();
      send_word(16'h0E2B, 12, 1'b1);
      chk("al_prelock", 32'(oLocked), 32'h1);
      send_word(16'h0E2B, 11, 1'b1);
      chk("al_pulse", 32'(oAlignErr), 32'h1);
      chk("al_stb",   32'(oWordStb),  32'h0);
      chk("al_lock",  32'(oLocked),   32'h0);
      chk("al_err",   32'(oErrCnt),   32'h1);
      bit_cycle(1'b0, 1'b0, 1'b0);
      chk("al_pulse_end", 32'(oAlignErr), 32'h0);

      // ---------------- sync found mid-stream ----------------
      do_reset();
      for (int w = 0; w <= 37; w++) begin
         send_word((w == 5 || w == 21 || w == 37) ? 16'h0E2B : 16'h0000, 12, 1'b1);
         if (w == 5) begin
            chk("ms5_idx",  32'(oWordIdx), 32'h0);
            chk("ms5_lock", 32'(oLocked),  32'h0);
         end
         if (w == 6)  chk("ms6_idx", 32'(oWordIdx), 32'h1);
         if (w == 21) begin
            chk("ms21_idx",  32'(oWordIdx), 32'h0);
            chk("ms21_lock", 32'(oLocked),  32'h1);
         end
         if (w == 37) begin
            chk("ms37_idx",  32'(oWordIdx),    32'h0);
            chk("ms37_lock", 32'(oLocked),     32'h1);
            chk("ms37_fs",   32'(oFrameStart), 32'h1);
         end
      end

      // ---------------- reset in the middle of a word ----------------
      send_word(16'h003F, 6, 1'b0);
      reset = 1'b0;
      #1;
      chk("mr_word", 32'(oWord),    32'h0);
      chk("mr_lock", 32'(oLocked),  32'h0);
      chk("mr_idx",  32'(oWordIdx), 32'h0);
      chk("mr_stb",  32'(oWordStb), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      // 12'h5A5: five bits, a stray valid without a bit strobe, seven bits.
      send_word(16'h000B, 5, 1'b0);
      bit_cycle(1'b1, 1'b1, 1'b0);
      chk("mr_stray_stb", 32'(oWordStb), 32'h0);
      send_word(16'h0025, 7, 1'b1);
      chk("mr_after_stb",   32'(oWordStb),  32'h1);
      chk("mr_after_word",  32'(oWord),     32'h5A5);
      chk("mr_after_align", 32'(oAlignErr), 32'h0);
      chk("mr_after_err",   32'(oErrCnt),   32'h0);

      // ---------------- error counter saturation ----------------
      do_reset();
      iSerial    = 1'b0;
      iBitEn     = 1'b1;
      iWordValid = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_pre",   32'(oErrCnt),   32'hFFFE);
      chk("sat_align", 32'(oAlignErr), 32'h1);
      repeat (6) @(posedge clk);
      #1;
      chk("sat_hold", 32'(oErrCnt), 32'hFFFF);
      iBitEn     = 1'b0;
      iWordValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("sat_idle", 32'(oErrCnt), 32'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
